// File: rtl/axi_led_fnd_mux.sv
// AXI4-Lite slave driving an LED bank and a multiplexed N-digit 7-segment display.
// Registers: LED, VALUE, CTRL, STATUS (RO), SCANDIV, ID (RO); words 6-7 answer SLVERR.
module axi_led_fnd_mux #(
   parameter int          C_S_AXI_DATA_WIDTH = 32,
   parameter int          C_S_AXI_ADDR_WIDTH = 5,
   parameter int          LED_WIDTH          = 16,
   parameter int          NUM_DIGITS         = 8,
   parameter logic [31:0] SCAN_DIV_RST       = 32'd100000
) (
   input  logic                            ACLK,
   input  logic                            ARESET,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
   input  logic                            S_AXI_AWVALID,
   output logic                            S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
   input  logic                            S_AXI_WVALID,
   output logic                            S_AXI_WREADY,
   output logic [1:0]                      S_AXI_BRESP,
   output logic                            S_AXI_BVALID,
   input  logic                            S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
   input  logic                            S_AXI_ARVALID,
   output logic                            S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
   output logic [1:0]                      S_AXI_RRESP,
   output logic                            S_AXI_RVALID,
   input  logic                            S_AXI_RREADY,
   output logic [LED_WIDTH-1:0]            led,
   output logic [NUM_DIGITS-1:0]           fnd_com,
   output logic [7:0]                      fnd_seg
);

   localparam logic [31:0] ID_VALUE  = 32'h4C46_0200;
   localparam logic [31:0] CTRL_MASK = 32'h00FF_FF03;
   localparam logic [2:0]  LAST_IDX  = 3'(NUM_DIGITS - 1);
   localparam logic [1:0]  RESP_OKAY = 2'b00;
   localparam logic [1:0]  RESP_SLV  = 2'b10;

   // Byte-lane merge of write data into an existing register value.
   function automatic logic [31:0] apply_strb(input logic [31:0] old_v, input logic [31:0] new_v,
                                              input logic [3:0] strb);
      logic [31:0] res;
      for (int b = 0; b < 4; b++) begin
         res[8*b +: 8] = strb[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
      end
      return res;
   endfunction

   // Hex nibble to active-high segments {g,f,e,d,c,b,a}.
   function automatic logic [6:0] hex_seg(input logic [3:0] nib);
      case (nib)
         4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
         4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
         4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
         4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  4'hF: return 7'h71;
         default: return 7'h00;
      endcase
   endfunction

   logic                 awready_q, arready_q, bvalid_q, rvalid_q;
   logic [1:0]           bresp_q, rresp_q;
   logic [31:0]          rdata_q;
   logic [LED_WIDTH-1:0] led_q, led_d, led_out_q;
   logic [31:0]          value_q, value_d, ctrl_q, ctrl_d, scandiv_q, scandiv_d;
   logic [31:0]          presc_q;
   logic [2:0]           index_q;
   logic                 blink_q;
   logic [15:0]          frame_q;
   logic [NUM_DIGITS-1:0] fnd_com_q, com_s;
   logic [7:0]           fnd_seg_q, seg_s;

   logic                 wr_en_s, rd_en_s, digit_on_s;
   logic [2:0]           wr_idx_s, rd_idx_s;
   logic [1:0]           wr_resp_s, rd_resp_s;
   logic [31:0]          rd_data_s, led_ext_s, merge_s;
   logic [7:0]           dig_en_s, dp_s;
   logic                 unused_addr_s;

   assign wr_en_s  = awready_q & S_AXI_AWVALID & S_AXI_WVALID;
   assign rd_en_s  = arready_q & S_AXI_ARVALID;
   assign wr_idx_s = S_AXI_AWADDR[4:2];
   assign rd_idx_s = S_AXI_ARADDR[4:2];
   assign unused_addr_s = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

   // Zero-extended LED value used both for reads and byte-lane merges.
   always_comb begin
      led_ext_s = 32'h0;
      led_ext_s[LED_WIDTH-1:0] = led_q;
   end

   // Register next-state: byte-strobed writes, RO and unmapped writes dropped.
   always_comb begin
      led_d     = led_q;
      value_d   = value_q;
      ctrl_d    = ctrl_q;
      scandiv_d = scandiv_q;
      merge_s   = 32'h0;
      wr_resp_s = RESP_OKAY;
      if (wr_en_s) begin
         case (wr_idx_s)
            3'd0: begin
               merge_s = apply_strb(led_ext_s, S_AXI_WDATA, S_AXI_WSTRB);
               led_d   = merge_s[LED_WIDTH-1:0];
            end
            3'd1: value_d = apply_strb(value_q, S_AXI_WDATA, S_AXI_WSTRB);
            3'd2: ctrl_d  = apply_strb(ctrl_q, S_AXI_WDATA, S_AXI_WSTRB) & CTRL_MASK;
            3'd4: begin
               merge_s   = apply_strb(scandiv_q, S_AXI_WDATA, S_AXI_WSTRB);
               scandiv_d = (merge_s < 32'd2) ? 32'd2 : merge_s;
            end
            3'd6, 3'd7: wr_resp_s = RESP_SLV;
            default: wr_resp_s = RESP_OKAY;
         endcase
      end else begin
         wr_resp_s = RESP_OKAY;
      end
   end

   // Read mux built from current register values, so a same-cycle write is not seen.
   always_comb begin
      rd_data_s = 32'h0;
      rd_resp_s = RESP_OKAY;
      case (rd_idx_s)
         3'd0: rd_data_s = led_ext_s;
         3'd1: rd_data_s = value_q;
         3'd2: rd_data_s = ctrl_q;
         3'd3: rd_data_s = {frame_q, 12'h000, blink_q, index_q};
         3'd4: rd_data_s = scandiv_q;
         3'd5: rd_data_s = ID_VALUE;
         default: rd_resp_s = RESP_SLV;
      endcase
   end

   // AXI handshakes: ready pulses, response valids held until accepted.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         awready_q <= 1'b0;
         arready_q <= 1'b0;
         bvalid_q  <= 1'b0;
         rvalid_q  <= 1'b0;
         bresp_q   <= 2'b00;
         rresp_q   <= 2'b00;
         rdata_q   <= 32'h0;
      end else begin
         awready_q <= ~awready_q & S_AXI_AWVALID & S_AXI_WVALID & ~bvalid_q;
         arready_q <= ~arready_q & S_AXI_ARVALID & ~rvalid_q;
         if (wr_en_s) begin
            bvalid_q <= 1'b1;
            bresp_q  <= wr_resp_s;
         end else if (bvalid_q && S_AXI_BREADY) begin
            bvalid_q <= 1'b0;
         end
         if (rd_en_s) begin
            rvalid_q <= 1'b1;
            rdata_q  <= rd_data_s;
            rresp_q  <= rd_resp_s;
         end else if (rvalid_q && S_AXI_RREADY) begin
            rvalid_q <= 1'b0;
         end
      end
   end

   // Programmable registers.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         led_q     <= '0;
         value_q   <= 32'h0;
         ctrl_q    <= 32'h0;
         scandiv_q <= SCAN_DIV_RST;
      end else begin
         led_q     <= led_d;
         value_q   <= value_d;
         ctrl_q    <= ctrl_d;
         scandiv_q <= scandiv_d;
      end
   end

   // Scan engine: prescaler, digit index, frame counter and blink phase.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         presc_q <= 32'h0;
         index_q <= 3'd0;
         frame_q <= 16'h0;
         blink_q <= 1'b0;
      end else if (ctrl_q[0]) begin
         // ">=" also catches a SCANDIV lowered below the running count
         if (presc_q >= scandiv_q - 32'd1) begin
            presc_q <= 32'h0;
            if (index_q == LAST_IDX) begin
               index_q <= 3'd0;
               frame_q <= frame_q + 16'd1;
               if (frame_q[5:0] == 6'h3F) begin
                  blink_q <= ~blink_q;
               end
            end else begin
               index_q <= index_q + 3'd1;
            end
         end else begin
            presc_q <= presc_q + 32'd1;
         end
      end
   end

   // Digit select and segment pattern for the current index; blank segments when no digit is lit.
   always_comb begin
      dig_en_s   = ctrl_q[23:16];
      dp_s       = ctrl_q[15:8];
      digit_on_s = ctrl_q[0] & dig_en_s[index_q] & ~(ctrl_q[1] & blink_q);
      com_s      = '1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         com_s[i] = ~(digit_on_s && (index_q == 3'(i)));
      end
      if (digit_on_s) begin
         seg_s = {~dp_s[index_q], ~hex_seg(value_q[{index_q, 2'b00} +: 4])};
      end else begin
         seg_s = 8'hFF;
      end
   end

   // Registered pin drivers.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         led_out_q <= '0;
         fnd_com_q <= '1;
         fnd_seg_q <= 8'hFF;
      end else begin
         led_out_q <= led_q;
         fnd_com_q <= com_s;
         fnd_seg_q <= seg_s;
      end
   end

   assign S_AXI_AWREADY = awready_q;
   assign S_AXI_WREADY  = awready_q;
   assign S_AXI_BVALID  = bvalid_q;
   assign S_AXI_BRESP   = bresp_q;
   assign S_AXI_ARREADY = arready_q;
   assign S_AXI_RVALID  = rvalid_q;
   assign S_AXI_RDATA   = rdata_q;
   assign S_AXI_RRESP   = rresp_q;
   assign led           = led_out_q;
   assign fnd_com       = fnd_com_q;
   assign fnd_seg       = fnd_seg_q;

endmodule
